// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// R-type Func codes, FSM state encoding and operation kind.
package mdu_pkg;

    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    function automatic logic is_signed_func(input logic [5:0] f);
        return (f == FUNC_MULT) || (f == FUNC_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the magnitude datapath: a shift-add multiply step or a
// restoring-division step on the {upper, lower} 2*WIDTH accumulator.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_e                  i_op,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opnd,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_part;
    logic [WIDTH:0] w_diff;

    // Multiply adds into the upper half and shifts right; divide shifts left
    // and keeps the trial difference only when it does not borrow.
    always_comb begin
        w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
               + (i_acc[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
        w_part = i_acc[2*WIDTH-1:WIDTH-1];
        w_diff = w_part - {1'b0, i_opnd};
        if (i_op == OP_MUL) begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end else if (w_diff[WIDTH]) begin
            o_acc = {w_part[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
        end else begin
            o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit with HI/LO registers. Operates on
// magnitudes for WIDTH steps, then applies sign correction in FIX.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    state_e               r_state, w_state_nxt;
    op_e                  r_op, w_op_nxt;
    logic                 r_signed, w_signed_nxt;
    logic                 r_sign_a, w_sign_a_nxt;
    logic                 r_sign_b, w_sign_b_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [2*WIDTH-1:0]   r_acc, w_acc_nxt;
    logic [WIDTH-1:0]     r_opnd, w_opnd_nxt;
    logic [WIDTH-1:0]     r_hi, w_hi_nxt;
    logic [WIDTH-1:0]     r_lo, w_lo_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_dbz, w_dbz_nxt;

    logic                 w_sgn;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [2*WIDTH-1:0]   w_step_acc;
    logic [2*WIDTH-1:0]   w_neg_acc;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_op   (r_op),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_step_acc)
    );

    // Next-state, datapath and HI/LO update decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_signed_nxt = r_signed;
        w_sign_a_nxt = r_sign_a;
        w_sign_b_nxt = r_sign_b;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_opnd_nxt   = r_opnd;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_done_nxt   = 1'b0;
        w_dbz_nxt    = 1'b0;

        w_sgn     = is_signed_func(func);
        w_abs_a   = cond_neg(a, w_sgn & a[WIDTH-1]);
        w_abs_b   = cond_neg(b, w_sgn & b[WIDTH-1]);
        w_neg_acc = {(2*WIDTH){1'b0}} - r_acc;

        case (r_state)
            IDLE: begin
                if (start) begin
                    case (func)
                        FUNC_MULT, FUNC_MULTU: begin
                            w_op_nxt     = OP_MUL;
                            w_signed_nxt = w_sgn;
                            w_sign_a_nxt = w_sgn & a[WIDTH-1];
                            w_sign_b_nxt = w_sgn & b[WIDTH-1];
                            w_acc_nxt    = {{WIDTH{1'b0}}, w_abs_b};
                            w_opnd_nxt   = w_abs_a;
                            w_cnt_nxt    = CNT_INIT;
                            w_state_nxt  = CALC;
                        end
                        FUNC_DIV, FUNC_DIVU: begin
                            if (b == {WIDTH{1'b0}}) begin
                                w_done_nxt = 1'b1;
                                w_dbz_nxt  = 1'b1;
                            end else begin
                                w_op_nxt     = OP_DIV;
                                w_signed_nxt = w_sgn;
                                w_sign_a_nxt = w_sgn & a[WIDTH-1];
                                w_sign_b_nxt = w_sgn & b[WIDTH-1];
                                w_acc_nxt    = {{WIDTH{1'b0}}, w_abs_a};
                                w_opnd_nxt   = w_abs_b;
                                w_cnt_nxt    = CNT_INIT;
                                w_state_nxt  = CALC;
                            end
                        end
                        FUNC_MTHI: w_hi_nxt = a;
                        FUNC_MTLO: w_lo_nxt = a;
                        default:   w_state_nxt = IDLE;
                    endcase
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                w_acc_nxt = w_step_acc;
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = FIX;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            FIX: begin
                if (r_op == OP_MUL) begin
                    if (r_signed && (r_sign_a != r_sign_b)) begin
                        {w_hi_nxt, w_lo_nxt} = w_neg_acc;
                    end else begin
                        {w_hi_nxt, w_lo_nxt} = r_acc;
                    end
                end else begin
                    w_lo_nxt = cond_neg(r_acc[WIDTH-1:0],
                                        r_signed & (r_sign_a ^ r_sign_b));
                    w_hi_nxt = cond_neg(r_acc[2*WIDTH-1:WIDTH], r_signed & r_sign_a);
                end
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        // busy covers the cycles between the first iteration edge and the FIX edge
        w_busy_nxt = (r_state != IDLE) && (w_state_nxt != IDLE);
    end

    // State, datapath and output registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= OP_MUL;
            r_signed <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_opnd   <= {WIDTH{1'b0}};
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_signed <= w_signed_nxt;
            r_sign_a <= w_sign_a_nxt;
            r_sign_b <= w_sign_b_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_opnd   <= w_opnd_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_dbz    <= w_dbz_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dbz  = r_dbz;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and random test of mdu_iter against a plain-arithmetic HI/LO model.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [5:0]   func;
    logic [W-1:0] a, b;
    logic         busy, done, dbz;
    logic [W-1:0] hi, lo;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_hi, exp_lo;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .func  (func),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .hi    (hi),
        .lo    (lo)
    );

    // Reference result {hi, lo} from the architectural definition.
    function automatic logic [63:0] ref_md(input logic [5:0] f,
                                           input logic [W-1:0] av,
                                           input logic [W-1:0] bv);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     p, q, r;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ua = {32'd0, av};
        ub = {32'd0, bv};
        case (f)
            FUNC_MULT:  begin p = sa * sb; return p; end
            FUNC_MULTU: begin p = ua * ub; return p; end
            FUNC_DIV:   begin sq = sa / sb; sr = sa % sb; q = sq; r = sr;
                              return {r[31:0], q[31:0]}; end
            FUNC_DIVU:  begin q = ua / ub; r = ua % ub;
                              return {r[31:0], q[31:0]}; end
            default:    return 64'd0;
        endcase
    endfunction

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Issues one request and checks its outcome; returns in the cycle after
    // completion so a following call exercises back-to-back acceptance.
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input string tag);
        logic [63:0] r;
        int          lat, nbusy;
        bit          md, dv;
        dv = (f == FUNC_DIV) || (f == FUNC_DIVU);
        md = dv || (f == FUNC_MULT) || (f == FUNC_MULTU);
        start = 1'b1; func = f; a = av; b = bv;
        tick();
        start = 1'b0;
        if (md && !(dv && bv == 32'd0)) begin
            r = ref_md(f, av, bv);
            exp_hi = r[63:32];
            exp_lo = r[31:0];
            lat = 0;
            nbusy = busy ? 1 : 0;
            while (!done && lat < 100) begin
                tick();
                lat++;
                if (busy) nbusy++;
            end
            check({tag, " latency"}, lat, W + 1);
            check({tag, " busy_cycles"}, nbusy, W);
            check({tag, " dbz"}, dbz, 1'b0);
            check({tag, " hi"}, hi, exp_hi);
            check({tag, " lo"}, lo, exp_lo);
        end else if (md) begin
            check({tag, " dbz_done"}, done, 1'b1);
            check({tag, " dbz"}, dbz, 1'b1);
            check({tag, " hi"}, hi, exp_hi);
            check({tag, " lo"}, lo, exp_lo);
        end else begin
            if (f == FUNC_MTHI) exp_hi = av;
            if (f == FUNC_MTLO) exp_lo = av;
            check({tag, " done"}, done, 1'b0);
            check({tag, " busy"}, busy, 1'b0);
            check({tag, " hi"}, hi, exp_hi);
            check({tag, " lo"}, lo, exp_lo);
        end
    endtask

    initial begin
        logic [5:0]   f;
        logic [W-1:0] av, bv, old_hi, old_lo;
        logic [63:0]  r;
        int           lat;
        bit           seen;
        logic [5:0]   md_funcs [4];
        logic [5:0]   bad_funcs [4];
        md_funcs  = '{FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU};
        bad_funcs = '{6'b100000, 6'b010000, 6'b010010, 6'b011100};

        rst_n = 1'b0; start = 1'b0; func = 6'd0; a = 32'd0; b = 32'd0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset dbz", dbz, 1'b0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        run_op(FUNC_MULT,  32'hFFFF_FFFF, 32'h0000_0002, "mult_m1x2");
        run_op(FUNC_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, "multu_big");
        run_op(FUNC_DIVU,  32'h0000_0007, 32'h0000_0002, "divu_7_2");
        run_op(FUNC_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2");
        run_op(FUNC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(FUNC_MTHI,  32'h0000_ABCD, 32'h0000_0000, "mthi");
        run_op(FUNC_MTLO,  32'h0000_ABCD, 32'h0000_0000, "mtlo");
        run_op(FUNC_DIVU,  32'h0000_0007, 32'h0000_0000, "divu_by0");
        tick();
        check("dbz pulse ends", dbz, 1'b0);
        run_op(6'b100000,  32'h1111_1111, 32'h2222_2222, "ignored_func");

        // Requests arriving mid-operation must not disturb HI/LO or the result.
        old_hi = exp_hi; old_lo = exp_lo;
        start = 1'b1; func = FUNC_MULT; a = 32'hFFFF_FFFF; b = 32'h0000_0003;
        tick();
        start = 1'b0;
        r = ref_md(FUNC_MULT, 32'hFFFF_FFFF, 32'h0000_0003);
        lat = 0;
        repeat (3) begin tick(); lat++; end
        check("busy mid_op", busy, 1'b1);
        start = 1'b1; func = FUNC_MTHI; a = 32'h1234_5678;
        tick(); lat++;
        func = FUNC_MULT; a = 32'h0000_0005; b = 32'h0000_0007;
        tick(); lat++;
        start = 1'b0;
        check("busy_ignore hi", hi, old_hi);
        check("busy_ignore lo", lo, old_lo);
        while (!done && lat < 100) begin tick(); lat++; end
        check("busy_ignore latency", lat, W + 1);
        exp_hi = r[63:32]; exp_lo = r[31:0];
        check("busy_ignore hi final", hi, exp_hi);
        check("busy_ignore lo final", lo, exp_lo);
        run_op(FUNC_MULT, 32'h0001_0000, 32'h0001_0000, "back_to_back");

        for (int i = 0; i < 40; i++) begin
            av = pick_val();
            bv = pick_val();
            case ($urandom_range(0, 7))
                0, 1, 2, 3: f = md_funcs[$urandom_range(0, 3)];
                4:          f = FUNC_MTHI;
                5:          f = FUNC_MTLO;
                6:          f = bad_funcs[$urandom_range(0, 3)];
                default:    begin f = md_funcs[$urandom_range(2, 3)]; bv = 32'd0; end
            endcase
            run_op(f, av, bv, $sformatf("rand%0d_f%02h", i, f));
        end

        // Asynchronous reset in the middle of an iteration.
        run_op(FUNC_MTHI, 32'h5A5A_5A5A, 32'h0, "pre_rst_mthi");
        run_op(FUNC_MTLO, 32'hA5A5_A5A5, 32'h0, "pre_rst_mtlo");
        start = 1'b1; func = FUNC_MULT; a = 32'h0000_0003; b = 32'h0000_0004;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("pre_rst busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst busy", busy, 1'b0);
        check("async_rst done", done, 1'b0);
        check("async_rst dbz", dbz, 1'b0);
        check("async_rst hi", hi, 32'd0);
        check("async_rst lo", lo, 32'd0);
        tick();
        rst_n = 1'b1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        check("post_rst no_activity", seen, 1'b0);
        check("post_rst hi", hi, exp_hi);
        check("post_rst lo", lo, exp_lo);
        run_op(FUNC_DIV, 32'h0000_0064, 32'hFFFF_FFF9, "post_rst_div");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath.
- Generalises the combinational ALU-control decode: it decodes the R-type Func field itself for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Mult/div run iteratively over WIDTH cycles behind a start/busy/done handshake.
- Sits beside the ALU in EX stage; the control unit stalls the PC while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width; any even value ≥ 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled each edge
- func  in  6  R-type Func field
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b  in  WIDTH  rt operand (divisor / multiplier)
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse when a mult/div completes
- dbz  out  1  one-cycle pulse, divide by zero; coincident with done
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, dbz=0, hi=0, lo=0; counter=0.
  - Asserted mid-operation, it aborts immediately with no partial write.
- Func decode:
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO.
  - Any other code with start=1 is ignored; no state change.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1, mult/div func:
  - Latch op and signedness.
  - Latch |a| and |b| (signed ops) or raw a and b (unsigned ops).
  - Record sign_a and sign_b; counter=WIDTH; go to CALC.
- IDLE, start=1, MTHI/MTLO:
  - hi<=a (MTHI) or lo<=a (MTLO) at the same edge; stay in IDLE; no done pulse.
- IDLE, DIV/DIVU with b==0:
  - No CALC; hi/lo unchanged.
  - Next edge: done=1, dbz=1; stay IDLE.
- CALC, multiply:
  - One shift-add step per edge on a 2*WIDTH accumulator.
- CALC, divide:
  - One restoring-division step per edge: shift remainder left, trial subtract, set quotient bit.
- CALC exit:
  - counter decrements each edge; leave for FIX when counter reaches 1 → exactly WIDTH CALC edges.
- FIX (one edge):
  - Apply sign correction.
  - Multiply: negate product if sign_a≠sign_b (signed only); hi<=upper half, lo<=lower half.
  - Divide: lo<=quotient, negated if sign_a≠sign_b; hi<=remainder, negated if sign_a=1 (signed only).
  - Same edge: done=1, state→IDLE.
- Latency and handshake:
  - Start sampled at edge k; busy=1 from edge k+1 through k+WIDTH+1 exclusive; done=1 for the cycle after edge k+WIDTH+1.
  - Latency is WIDTH+1 edges; hi/lo update on the same edge done rises.
  - start while busy=1 is ignored (including MTHI/MTLO); hi/lo are not touched.
  - A new start during the done cycle is accepted (back-to-back).
- Overflow:
  - DIV of −2^(WIDTH−1) by −1 gives lo=0x80..0, hi=0 (natural wrap); no exception.
- Width rules:
  - Magnitude of −2^(WIDTH−1) is held as unsigned WIDTH bits; the accumulator is 2*WIDTH bits, so no overflow is possible.
- hi/lo hold their values indefinitely outside MTHI/MTLO/FIX writes.

Decomposition:
- Package mdu_pkg:
  - Func code localparams: FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU, FUNC_MTHI, FUNC_MTLO.
  - State encoding IDLE/CALC/FIX.
  - Op enum {OP_MUL, OP_DIV}.
- One sub-module, mdu_step:
  - Combinational single-iteration datapath (shift-add or shift-subtract) on accumulator and operand.
  - The top holds the FSM, counter and HI/LO.

Test Plan (WIDTH=32):
- MULT a=FFFFFFFF, b=00000002 at edge k → done at k+33, hi=FFFFFFFF, lo=FFFFFFFE; busy high 32 cycles.
- MULTU a=FFFFFFFF, b=00000002 → hi=00000001, lo=FFFFFFFE; DIVU a=7, b=2 → lo=3, hi=1.
- DIV a=FFFFFFF9 (−7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF; DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0.
- DIVU a=7, b=0 with hi=lo=0000ABCD preset via MTHI/MTLO → done=dbz=1 one edge later, hi/lo still 0000ABCD.
- MULT started, MTHI a=12345678 and second start issued while busy → both ignored; original product lands; back-to-back MULT in done cycle accepted.
- rst_n pulsed low at CALC iteration 10 → busy/done/hi/lo=0 immediately (async), no done pulse after release.
